// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci term sequencer.
// Optional build macro (used by fib_sequencer): FIB_OVERFLOW_STOP_EN.
package fib_pkg;

    localparam int FIB_WIDTH = 4;
    localparam int FIB_CNT_W = 4;

    // Fixed 2-bit encoding so the state can be probed/compared across builds.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } fib_state_t;

    // Any state other than IDLE counts as an active run.
    function automatic logic state_is_busy(input fib_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/fib_core.sv
// Two-register Fibonacci datapath with per-register wrap tracking.
// clear loads a=0, b=1; step advances (a, b) <= (b, a+b mod 2^WIDTH).
// The b wrap flag is sticky down the sequence: once any term wraps,
// every later term is also marked as wrapped.
import fib_pkg::*;

module fib_core #(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             a_wrap
);

    logic [WIDTH-1:0] b;
    logic             b_wrap;
    logic [WIDTH:0]   sum_full;

    // Full-width sum so the carry-out is visible as the wrap indication.
    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
    end

    // Core registers: clear takes priority over step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            a_wrap <= 1'b0;
            b_wrap <= 1'b0;
        end else if (clear) begin
            a      <= '0;
            b      <= {{(WIDTH-1){1'b0}}, 1'b1};
            a_wrap <= 1'b0;
            b_wrap <= 1'b0;
        end else if (step) begin
            a      <= b;
            a_wrap <= b_wrap;
            b      <= sum_full[WIDTH-1:0];
            b_wrap <= sum_full[WIDTH] | a_wrap | b_wrap;
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// Runs the Fibonacci core for a requested number of terms and streams each
// term over a valid/ready handshake. Reports busy, a one-cycle done pulse
// and a sticky ovf flag for wrapped terms.
// Build option: FIB_OVERFLOW_STOP_EN -- when defined, the run ends early at
// the first wrapped term instead of emitting it truncated.
//
// state  | meaning
// IDLE   | waiting for start; n_terms latched on accepted start
// LOAD   | core cleared (a=0, b=1), counter zeroed
// EMIT   | term a presented with out_valid; core steps on handshake
// FINISH | done pulse for one cycle, then back to IDLE
import fib_pkg::*;

module fib_sequencer #(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] term_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    fib_state_t       state;
    fib_state_t       state_nxt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             core_clear;
    logic             core_step;
    logic             ovf_set;
    logic             last_term;
    logic [WIDTH-1:0] core_a;
    logic             core_a_wrap;

    fib_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clear  (core_clear),
        .step   (core_step),
        .a      (core_a),
        .a_wrap (core_a_wrap)
    );

    // Final term of the run is the one whose index is n_terms-1.
    always_comb begin
        last_term = (cnt == (n_lat - {{(CNT_W-1){1'b0}}, 1'b1}));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        core_clear = 1'b0;
        core_step  = 1'b0;
        ovf_set    = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_clear = 1'b1;
                state_nxt  = (n_lat == '0) ? FINISH : EMIT;
            end
            EMIT: begin
`ifdef FIB_OVERFLOW_STOP_EN
                if (core_a_wrap) begin
                    // Wrapped term is suppressed; the run ends here.
                    ovf_set   = 1'b1;
                    state_nxt = FINISH;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        core_step = 1'b1;
                        if (last_term) begin
                            state_nxt = FINISH;
                        end
                    end
                end
`else
                out_valid = 1'b1;
                if (out_ready) begin
                    core_step = 1'b1;
                    ovf_set   = core_a_wrap;
                    if (last_term) begin
                        state_nxt = FINISH;
                    end
                end
`endif
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run length latch: only an accepted start may change it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat <= '0;
        end else if (accept) begin
            n_lat <= n_terms;
        end
    end

    // Term counter: zeroed in LOAD, advanced on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (core_clear) begin
            cnt <= '0;
        end else if (core_step) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky overflow: cleared by an accepted start, set by a wrapped term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    // Output mapping; a and cnt are both zero out of reset.
    always_comb begin
        out_data = core_a;
        term_idx = cnt;
        busy     = state_is_busy(state);
    end

endmodule

// File: tb/tb_fib_sequencer.sv
module tb_fib_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
`ifdef FIB_OVERFLOW_STOP_EN
    localparam int N10_TERMS = 8;
`else
    localparam int N10_TERMS = 10;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] term_idx;
    logic             busy;
    logic             done;
    logic             ovf;

    int passes = 0;
    int total  = 0;

    // F(i) mod 16, hand-computed: 21->5, 34->2, 55->7, 89->9, 144->0, 233->9, 377->9
    logic [3:0] fib_tab [0:15] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13,
                                   4'd5, 4'd2, 4'd7, 4'd9, 4'd0, 4'd9, 4'd9, 4'd2};

    fib_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .term_idx  (term_idx),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Start a run at the next edge and follow it to the done pulse.
    // pat: 0 = ready always high, 1 = ready pattern 1,0,0,1 repeating.
    // c counts negedges after the accepting edge (c=0 is the LOAD cycle).
    task automatic run(input int n, input int pat, input bit poke, input int exp_got,
                       input int exp_ovf_from,
                       output int got, output int first_v, output int done_c);
        bit rdy;
        got = 0; first_v = -1; done_c = -1;
        n_terms = CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rdy = (pat == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                if (got >= exp_got) begin
                    check("extra_term", got, exp_got - 1);
                end else begin
                    check($sformatf("data[%0d]", got), out_data, fib_tab[got]);
                    check($sformatf("idx[%0d]", got), term_idx, got);
                    check($sformatf("ovf_at[%0d]", got), ovf, (got > exp_ovf_from) ? 1 : 0);
                end
                if (rdy) got++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            out_ready = rdy;
            if (poke && c == 3) begin
                start = 1'b1;
                n_terms = CNT_W'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("run_timeout", (done_c < 0) ? 1 : 0, 0);
        check("done_busy", busy, 1);
        check("done_no_valid", out_valid, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int got, fv, dc;
        rst = 1'b1; start = 1'b0; n_terms = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx", term_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // n=8 full throughput: first valid 2 cycles after start edge, done after 8 terms
        run(8, 0, 1'b0, 8, 99, got, fv, dc);
        check("n8_count", got, 8);
        check("n8_first_valid", fv, 1);
        check("n8_done_cycle", dc, 9);
        check("n8_ovf", ovf, 0);

        // n=10: F(8)/F(9) wrap
        run(10, 0, 1'b0, N10_TERMS, 8, got, fv, dc);
        check("n10_count", got, N10_TERMS);
        check("n10_ovf", ovf, 1);

        // n=0: done two cycles after start, no valid; ovf cleared by start
        run(0, 0, 1'b0, 0, 99, got, fv, dc);
        check("n0_count", got, 0);
        check("n0_first_valid", fv, -1);
        check("n0_done_cycle", dc, 1);
        check("n0_ovf_cleared", ovf, 0);

        // stalls with ready 1,0,0,1 and a start pulse while busy
        run(5, 1, 1'b1, 5, 99, got, fv, dc);
        check("stall_count", got, 5);
        check("stall_no_restart", busy, 0);
        @(negedge clk);
        check("stall_still_idle", busy, 0);

        // asynchronous reset in the middle of EMIT
        n_terms = CNT_W'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_data", out_data, 0);
        check("arst_idx", term_idx, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(3, 0, 1'b0, 3, 99, got, fv, dc);
        check("post_rst_count", got, 3);
        check("post_rst_first_valid", fv, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
